// File: rtl/cory_merge4_if.sv
// Bundle of the four producer streams, the channel mask and the merged
// output stream of cory_merge4.
interface cory_merge4_if #(
  parameter int N = 16
);
  logic         i_a0_v;
  logic [N-1:0] i_a0_d;
  logic         o_a0_r;
  logic         i_a1_v;
  logic [N-1:0] i_a1_d;
  logic         o_a1_r;
  logic         i_a2_v;
  logic [N-1:0] i_a2_d;
  logic         o_a2_r;
  logic         i_a3_v;
  logic [N-1:0] i_a3_d;
  logic         o_a3_r;
  logic [3:0]   i_mask;
  logic         o_z_v;
  logic [N-1:0] o_z_d;
  logic [1:0]   o_z_s;
  logic         i_z_r;
  logic [15:0]  o_cnt;

  // Producer/consumer side (drives channel inputs, takes the merged stream).
  modport master (
    output i_a0_v, i_a0_d, i_a1_v, i_a1_d, i_a2_v, i_a2_d, i_a3_v, i_a3_d,
    output i_mask, i_z_r,
    input  o_a0_r, o_a1_r, o_a2_r, o_a3_r, o_z_v, o_z_d, o_z_s, o_cnt
  );

  // Merge side.
  modport slave (
    input  i_a0_v, i_a0_d, i_a1_v, i_a1_d, i_a2_v, i_a2_d, i_a3_v, i_a3_d,
    input  i_mask, i_z_r,
    output o_a0_r, o_a1_r, o_a2_r, o_a3_r, o_z_v, o_z_d, o_z_s, o_cnt
  );
endinterface

// File: rtl/cory_merge4.sv
// Round-robin 4-to-1 stream merge with a registered, source-tagged output
// stage and a delivered-item counter.
module cory_merge4 #(
  parameter int N  = 16,
  parameter int P0 = 0
) (
  input logic         clk,
  input logic         reset_n,
  cory_merge4_if.slave bus
);
  localparam logic [1:0] PTR_RST = 2'(P0);

  logic [3:0]   v;
  logic [3:0]   e;
  logic [3:0]   rdy;
  logic [7:0]   e_dbl;
  logic [3:0]   e_rot;
  logic [N-1:0] d [4];
  logic [1:0]   off;
  logic [1:0]   grant;
  logic         grant_valid;
  logic         can_load;
  logic         load;

  logic         z_v_reg;
  logic [N-1:0] z_d_reg;
  logic [1:0]   z_s_reg;
  logic [1:0]   ptr_reg;
  logic [15:0]  cnt_reg;

  assign v    = {bus.i_a3_v, bus.i_a2_v, bus.i_a1_v, bus.i_a0_v};
  assign d[0] = bus.i_a0_d;
  assign d[1] = bus.i_a1_d;
  assign d[2] = bus.i_a2_d;
  assign d[3] = bus.i_a3_d;

  assign can_load = ~z_v_reg | bus.i_z_r;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      assign e[gi]   = v[gi] & ~bus.i_mask[gi];
      assign rdy[gi] = can_load & grant_valid & (grant == 2'(gi)) & reset_n;
    end
  endgenerate

  // Rotate the eligible set so bit 0 is the channel at ptr; the first set
  // bit then gives the grant offset from ptr.
  assign e_dbl = {e, e};
  assign e_rot = e_dbl[ptr_reg +: 4];

  always_comb begin
    off = 2'd0;
    if (e_rot[0])      off = 2'd0;
    else if (e_rot[1]) off = 2'd1;
    else if (e_rot[2]) off = 2'd2;
    else if (e_rot[3]) off = 2'd3;
  end

  assign grant_valid = |e;
  assign grant       = ptr_reg + off;
  assign load        = can_load & grant_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z_v_reg <= 1'b0;
      z_d_reg <= '0;
      z_s_reg <= 2'd0;
      ptr_reg <= PTR_RST;
      cnt_reg <= 16'd0;
    end else begin
      if (load) begin
        z_v_reg <= 1'b1;
        z_d_reg <= d[grant];
        z_s_reg <= grant;
        ptr_reg <= grant + 2'd1;
      end else if (bus.i_z_r) begin
        z_v_reg <= 1'b0;
      end
      if (z_v_reg & bus.i_z_r) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign bus.o_a0_r = rdy[0];
  assign bus.o_a1_r = rdy[1];
  assign bus.o_a2_r = rdy[2];
  assign bus.o_a3_r = rdy[3];
  assign bus.o_z_v  = z_v_reg;
  assign bus.o_z_d  = z_d_reg;
  assign bus.o_z_s  = z_s_reg;
  assign bus.o_cnt  = cnt_reg;
endmodule
